// File: rtl/riscv_alu_issue_if.sv
// Handshake bundle for the decode/issue stage: fetch/regfile side (in_*) and ALU side (out_*).
// Also holds the ALU operation codes shared by the stage and its consumers.
`ifndef ALU_OP_LEN
`define ALU_OP_LEN  4
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUB  4'd1
`define ALU_OP_SLL  4'd2
`define ALU_OP_SLT  4'd3
`define ALU_OP_SLTU 4'd4
`define ALU_OP_XOR  4'd5
`define ALU_OP_SRL  4'd6
`define ALU_OP_SRA  4'd7
`define ALU_OP_OR   4'd8
`define ALU_OP_AND  4'd9
`endif

interface riscv_alu_issue_if;
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [31:0]             in_instr;
   logic [31:0]             in_pc;
   logic [31:0]             in_rs1_data;
   logic [31:0]             in_rs2_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [`ALU_OP_LEN-1:0]  alu_op;
   logic [31:0]             operand_1;
   logic [31:0]             operand_2;
   logic [31:0]             out_pc;
   logic [4:0]              out_rd;
   logic                    out_reg_write;
   logic                    out_is_branch;
   logic                    out_take_on_zero;
   logic                    out_illegal;

   modport slave (
      input  flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
      output in_ready, out_valid, alu_op, operand_1, operand_2, out_pc, out_rd,
             out_reg_write, out_is_branch, out_take_on_zero, out_illegal
   );

   modport master (
      output flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
      input  in_ready, out_valid, alu_op, operand_1, operand_2, out_pc, out_rd,
             out_reg_write, out_is_branch, out_take_on_zero, out_illegal
   );
endinterface

// File: rtl/riscv_alu_issue.sv
// RV32I decode/issue stage feeding the ALU through a registered ID/EX slot with valid/ready.
// Define RISCV_ISSUE_SKID_EN to add a one-entry skid buffer that makes in_ready a registered signal.
module riscv_alu_issue #(
   parameter int DATA_W         = 32,
   parameter bit ILLEGAL_BUBBLE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   riscv_alu_issue_if.slave  bus
);
   typedef struct packed {
      logic [`ALU_OP_LEN-1:0] alu_op;
      logic [DATA_W-1:0]      op1;
      logic [DATA_W-1:0]      op2;
      logic [DATA_W-1:0]      pc;
      logic [4:0]             rd;
      logic                   reg_write;
      logic                   is_branch;
      logic                   take_on_zero;
      logic                   illegal;
   } entry_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [31:0]       instr;
   logic [6:0]        opcode;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [DATA_W-1:0] i_imm, s_imm, u_imm, shamt;
   entry_t            dec;
   logic              legal, writes;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign i_imm  = {{20{instr[31]}}, instr[31:20]};
   assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign u_imm  = {instr[31:12], 12'b0};
   assign shamt  = {27'b0, instr[24:20]};

   // Shared f3 mapping for OP and OP-IMM; shifts and SUB are overridden by the caller.
   function automatic logic [`ALU_OP_LEN-1:0] f3_op(input logic [2:0] f);
      case (f)
         3'b000:  f3_op = `ALU_OP_ADD;
         3'b001:  f3_op = `ALU_OP_SLL;
         3'b010:  f3_op = `ALU_OP_SLT;
         3'b011:  f3_op = `ALU_OP_SLTU;
         3'b100:  f3_op = `ALU_OP_XOR;
         3'b101:  f3_op = `ALU_OP_SRL;
         3'b110:  f3_op = `ALU_OP_OR;
         default: f3_op = `ALU_OP_AND;
      endcase
   endfunction

   always_comb begin
      dec        = '0;
      dec.alu_op = `ALU_OP_ADD;
      dec.op1    = bus.in_rs1_data;
      dec.op2    = bus.in_rs2_data;
      dec.pc     = bus.in_pc;
      dec.rd     = instr[11:7];
      legal      = 1'b1;
      writes     = 1'b1;
      case (opcode)
         OPC_OP: begin
            if (f7 == 7'b0)
               dec.alu_op = f3_op(f3);
            else if (f7 == F7_ALT && f3 == 3'b000)
               dec.alu_op = `ALU_OP_SUB;
            else if (f7 == F7_ALT && f3 == 3'b101)
               dec.alu_op = `ALU_OP_SRA;
            else
               legal = 1'b0;
         end
         OPC_OP_IMM: begin
            dec.op2    = i_imm;
            dec.alu_op = f3_op(f3);
            if (f3 == 3'b001) begin
               dec.op2 = shamt;
               legal   = (f7 == 7'b0);
            end else if (f3 == 3'b101) begin
               dec.op2 = shamt;
               if (f7 == F7_ALT)
                  dec.alu_op = `ALU_OP_SRA;
               else if (f7 != 7'b0)
                  legal = 1'b0;
            end
         end
         OPC_LOAD: begin
            dec.op2 = i_imm;
            legal   = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
         end
         OPC_STORE: begin
            dec.op2 = s_imm;
            dec.rd  = 5'd0;
            writes  = 1'b0;
            legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
         end
         OPC_LUI: begin
            dec.op1 = '0;
            dec.op2 = u_imm;
         end
         OPC_AUIPC: begin
            dec.op1 = bus.in_pc;
            dec.op2 = u_imm;
         end
         OPC_JAL, OPC_JALR: begin
            // Link value pc+4 goes through the ALU; the jump target is computed elsewhere.
            dec.op1 = bus.in_pc;
            dec.op2 = 32'd4;
            legal   = (opcode == OPC_JAL) || (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            dec.rd        = 5'd0;
            writes        = 1'b0;
            dec.is_branch = 1'b1;
            case (f3)
               3'b000:  begin dec.alu_op = `ALU_OP_SUB;  dec.take_on_zero = 1'b1; end
               3'b001:  begin dec.alu_op = `ALU_OP_SUB;  dec.take_on_zero = 1'b0; end
               3'b100:  begin dec.alu_op = `ALU_OP_SLT;  dec.take_on_zero = 1'b0; end
               3'b101:  begin dec.alu_op = `ALU_OP_SLT;  dec.take_on_zero = 1'b1; end
               3'b110:  begin dec.alu_op = `ALU_OP_SLTU; dec.take_on_zero = 1'b0; end
               3'b111:  begin dec.alu_op = `ALU_OP_SLTU; dec.take_on_zero = 1'b1; end
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.illegal      = 1'b1;
         dec.alu_op       = `ALU_OP_ADD;
         dec.is_branch    = 1'b0;
         dec.take_on_zero = 1'b0;
         if (ILLEGAL_BUBBLE)
            writes = 1'b0;
      end
      dec.reg_write = writes && (dec.rd != 5'd0);
   end

   logic   valid_q, valid_d;
   entry_t slot_q, slot_d;
   logic   in_ready;
   logic   accept;

   assign accept = bus.in_valid && in_ready && !bus.flush;

`ifdef RISCV_ISSUE_SKID_EN
   logic   skid_valid_q, skid_valid_d;
   entry_t skid_q, skid_d;
   logic   slot_free;

   assign in_ready = !skid_valid_q;

   always_comb begin
      valid_d      = valid_q;
      slot_d       = slot_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      slot_free    = !valid_q || bus.out_ready;
      if (bus.flush) begin
         valid_d      = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // Nothing can be accepted while the skid is full, so just drain it in order.
         if (slot_free) begin
            slot_d       = skid_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (slot_free) begin
            slot_d  = dec;
            valid_d = 1'b1;
         end else begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
      end
   end
`else
   assign in_ready = !valid_q || bus.out_ready;

   always_comb begin
      valid_d = valid_q;
      slot_d  = slot_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         slot_d  = dec;
         valid_d = 1'b1;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else begin
         valid_q <= valid_d;
         slot_q  <= slot_d;
      end
   end

   assign bus.in_ready         = in_ready;
   assign bus.out_valid        = valid_q;
   assign bus.alu_op           = slot_q.alu_op;
   assign bus.operand_1        = slot_q.op1;
   assign bus.operand_2        = slot_q.op2;
   assign bus.out_pc           = slot_q.pc;
   assign bus.out_rd           = slot_q.rd;
   assign bus.out_reg_write    = slot_q.reg_write;
   assign bus.out_is_branch    = slot_q.is_branch;
   assign bus.out_take_on_zero = slot_q.take_on_zero;
   assign bus.out_illegal      = slot_q.illegal;
endmodule
